next_level_responder: RTL and testbench

Responder for the 26-bit line-address traffic that the L1 instruction and data caches send toward the next level. It accepts one line request per cycle into a small FIFO and services requests one at a time with a fixed memory latency. Each serviced request produces a response beat with a valid/ready handshake. It keeps read/write/stall statistics for the statistics module, sitting between the L1 caches and the L2/memory model.

---
 rtl/next_level_responder_pkg.sv | 21 ++
 rtl/next_level_responder_if.sv | 28 ++
 rtl/next_level_responder_line_req_fifo.sv | 52 +++++
 rtl/next_level_responder.sv | 116 +++++++++++
 tb/tb_next_level_responder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/next_level_responder_pkg.sv
// Shared definitions for the next-level responder: default widths, trace
// command encodings and the service FSM state encoding.
package next_level_responder_pkg;

  localparam int ADDR_W_DEF = 26;

  typedef enum logic [3:0] {
    CMD_READ       = 4'd0,
    CMD_WRITE      = 4'd1,
    CMD_INVALIDATE = 4'd3,
    CMD_RESET      = 4'd8,
    CMD_PRINT      = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/next_level_responder_if.sv
// Request/response handshake bundle between the L1 caches (master) and the
// next-level responder (slave).
interface next_level_responder_if
  import next_level_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_write;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_ready;

  modport master (
    output req_valid, req_write, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_addr
  );

  modport slave (
    input  req_valid, req_write, req_addr, resp_ready,
    output req_ready, resp_valid, resp_write, resp_addr
  );

endinterface

// File: rtl/next_level_responder_line_req_fifo.sv
// Request FIFO: DEPTH x WIDTH storage with wrap-bit pointers; clr empties it
// and takes priority over push/pop in the same cycle.
module line_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; empty/full are derived from the pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/next_level_responder.sv
// Next-level responder: queues L1 line requests, services them one at a time
// with a fixed latency, returns a response beat and keeps traffic counters.
module next_level_responder
  import next_level_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  next_level_responder_if.slave  bus,
  output logic [31:0]            l2_reads,
  output logic [31:0]            l2_writes,
  output logic [31:0]            stall_cycles
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e            state;
  state_e            state_nxt;
  logic [CW-1:0]     cnt;
  logic              svc_write;
  logic [ADDR_W-1:0] svc_addr;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   fifo_dout;

  assign push          = bus.req_valid && !full;
  assign bus.req_ready = !full;
  assign bus.resp_write = svc_write;
  assign bus.resp_addr  = svc_addr;

  line_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({bus.req_write, bus.req_addr}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= ST_IDLE;
    else if (clr) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!empty)           state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == '0)        state_nxt = ST_RESP;
      ST_RESP: if (bus.resp_ready)   state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop            = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      ST_IDLE: pop = !empty && !clr;
      ST_RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Service register keeps the popped entry so resp_addr/resp_write stay stable in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      svc_write <= 1'b0;
      svc_addr  <= '0;
    end else if (clr) begin
      cnt       <= '0;
      svc_write <= 1'b0;
      svc_addr  <= '0;
    end else if (pop) begin
      cnt       <= CNT_LOAD;
      svc_write <= fifo_dout[ADDR_W];
      svc_addr  <= fifo_dout[ADDR_W-1:0];
    end else if (state == ST_BUSY && cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_reads     <= '0;
      l2_writes    <= '0;
      stall_cycles <= '0;
    end else if (clr) begin
      l2_reads     <= '0;
      l2_writes    <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && bus.req_write)  l2_writes    <= l2_writes + 32'd1;
      if (push && !bus.req_write) l2_reads     <= l2_reads + 32'd1;
      if (bus.req_valid && full)  stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_next_level_responder.sv
// Self-checking bench for next_level_responder: directed scenarios plus a
// randomized phase, all compared against a queue-and-timer reference model.
module tb_next_level_responder;

  localparam int AW      = 26;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] l2_reads;
  logic [31:0] l2_writes;
  logic [31:0] stall_cycles;

  next_level_responder_if #(.ADDR_W(AW)) bus ();

  next_level_responder #(
    .ADDR_W  (AW),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .bus          (bus),
    .l2_reads     (l2_reads),
    .l2_writes    (l2_writes),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending requests in a queue, one request in service
  // that becomes visible LATENCY edges after it is taken from the queue.
  logic [AW:0] m_q[$];
  bit          m_active;
  int          m_remain;
  logic [AW:0] m_svc;
  logic [31:0] m_reads, m_writes, m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_remain = 0;
    m_svc    = '0;
    m_reads  = '0;
    m_writes = '0;
    m_stall  = '0;
  endtask

  task automatic model_edge();
    bit room;
    bit popped;
    room = (m_q.size() < DEPTH);
    if (clr) begin
      model_reset();
      return;
    end
    if (bus.req_valid && !room) m_stall++;
    popped = 0;
    if (!m_active && m_q.size() > 0) begin
      m_svc    = m_q.pop_front();
      m_active = 1;
      m_remain = LATENCY;
      popped   = 1;
    end else if (m_active && m_remain > 0) begin
      m_remain--;
    end else if (m_active && bus.resp_ready) begin
      m_active = 0;
    end
    if (bus.req_valid && room) begin
      m_q.push_back({bus.req_write, bus.req_addr});
      if (bus.req_write) m_writes++;
      else               m_reads++;
    end
  endtask

  task automatic compare_all();
    bit exp_valid;
    exp_valid = m_active && (m_remain == 0);
    check("req_ready", {31'd0, bus.req_ready}, {31'd0, (m_q.size() < DEPTH)});
    check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("resp_addr", {6'd0, bus.resp_addr}, {6'd0, m_svc[AW-1:0]});
      check("resp_write", {31'd0, bus.resp_write}, {31'd0, m_svc[AW]});
    end
    check("l2_reads", l2_reads, m_reads);
    check("l2_writes", l2_writes, m_writes);
    check("stall_cycles", stall_cycles, m_stall);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input bit w, input logic [AW-1:0] a, input bit rr, input bit c);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.resp_ready = rr;
    clr            = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_resp_write"}, {31'd0, bus.resp_write}, 32'd0);
    check({tag, "_resp_addr"}, {6'd0, bus.resp_addr}, 32'd0);
    check({tag, "_l2_reads"}, l2_reads, 32'd0);
    check({tag, "_l2_writes"}, l2_writes, 32'd0);
    check({tag, "_stall"}, stall_cycles, 32'd0);
  endtask

  task automatic single_read_latency(input string tag);
    int lat;
    drive(1, 0, 26'h0ABCDEF, 1, 0);
    cycle();
    drive(0, 0, '0, 1, 0);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, LATENCY + 1);
    check({tag, "_addr"}, {6'd0, bus.resp_addr}, 32'h00ABCDEF);
    check({tag, "_write"}, {31'd0, bus.resp_write}, 32'd0);
    check({tag, "_reads"}, l2_reads, 32'd1);
    cycle();
    check({tag, "_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read into an empty FIFO.
    single_read_latency("first_read");

    // Back-to-back pushes with the consumer stalled: FIFO fills, stalls accrue.
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], AW'(26'h100 + i), 0, 0);
      cycle();
    end
    check("fill_ready_low", {31'd0, bus.req_ready}, 32'd0);
    // Hold the response for 10 cycles, then drain with push pressure still on.
    drive(0, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
    drive(1, 1, 26'h3FFFFFF, 1, 0);
    for (int i = 0; i < 6; i++) cycle();
    drive(0, 0, '0, 1, 0);
    for (int i = 0; i < 40; i++) cycle();

    // clr while BUSY with three entries queued.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, AW'(26'h2000 + i), 0, 0);
      cycle();
    end
    drive(0, 0, '0, 1, 1);
    cycle();
    check_reset_outputs("clr");
    drive(0, 0, '0, 1, 0);
    for (int i = 0; i < 10; i++) cycle();

    // Asynchronous reset between edges while a response is presented.
    drive(1, 1, 26'h155AA55, 0, 0);
    cycle();
    drive(0, 0, '0, 0, 0);
    guard = 0;
    while (!(m_active && m_remain == 0) && guard < 20) begin
      cycle();
      guard++;
    end
    check("reach_resp", {31'd0, bus.resp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    single_read_latency("after_rst");

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, AW'($urandom),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
